// File: rtl/multicycle_ctrl_pkg.sv
// Shared MIPS definitions: opcodes, ALU/mux encodings, multicycle FSM states
// and the control bundle produced by the multicycle output decoder.
package mips_pkg;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] J     = 6'b000010;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] BNE   = 6'b000101;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] SLTI  = 6'b001010;
    localparam logic [5:0] ANDI  = 6'b001100;
    localparam logic [5:0] ORI   = 6'b001101;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;

    localparam logic [2:0] ALUOP_AND   = 3'b000;
    localparam logic [2:0] ALUOP_OR    = 3'b001;
    localparam logic [2:0] ALUOP_ADD   = 3'b010;
    localparam logic [2:0] ALUOP_FUNCT = 3'b011;
    localparam logic [2:0] ALUOP_SUB   = 3'b110;
    localparam logic [2:0] ALUOP_SLT   = 3'b111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUSRCB_RT     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_IEXEC,
        S_IWB,
        S_JUMP,
        S_ILLEGAL
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       ext_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    // Immediate-ALU instructions: only addi/slti sign-extend.
    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            ANDI:    return ALUOP_AND;
            ORI:     return ALUOP_OR;
            SLTI:    return ALUOP_SLT;
            default: return ALUOP_ADD;
        endcase
    endfunction

    function automatic logic imm_sign_ext(input logic [5:0] op);
        return (op == ADDI) || (op == SLTI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. The controller is the master.
interface multicycle_ctrl_if;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       MemReq;
    logic       MemWrite;
    logic       IorD;
    logic       IrWrite;
    logic       PcEn;
    logic [1:0] PcSrc;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic [2:0] AluOp;
    logic       ExtOp;
    logic       RegDst;
    logic       MemToReg;
    logic       RegWrite;
    logic       InstrDone;
    logic       Illegal;

    modport master (
        input  Op, Zero, MemReady,
        output MemReq, MemWrite, IorD, IrWrite, PcEn, PcSrc, AluSrcA, AluSrcB,
               AluOp, ExtOp, RegDst, MemToReg, RegWrite, InstrDone, Illegal
    );

    modport slave (
        output Op, Zero, MemReady,
        input  MemReq, MemWrite, IorD, IrWrite, PcEn, PcSrc, AluSrcA, AluSrcB,
               AluOp, ExtOp, RegDst, MemToReg, RegWrite, InstrDone, Illegal
    );
endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational map from FSM state, latched opcode and handshake/flag inputs
// to the per-cycle datapath control bundle.
module multicycle_outdec
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opq,
    input  logic       mem_rdy,
    input  logic       zero,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = ALUSRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_rdy;
                ctrl.pc_en     = mem_rdy;
            end
            S_DECODE: begin
                ctrl.alu_src_b = ALUSRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ext_op    = 1'b1;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ext_op    = 1'b1;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req    = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_rdy;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = ALUSRCB_RT;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.instr_done = 1'b1;
                ctrl.pc_en      = zero ^ (opq == BNE);
            end
            // Writeback keeps the ALU driving the same result it computed in IEXEC.
            S_IEXEC, S_IWB: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = imm_alu_op(opq);
                ctrl.ext_op    = imm_sign_ext(opq);
                if (state == S_IWB) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
            end
            S_JUMP: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_en      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ILLEGAL: ctrl.illegal = 1'b1;
            default:   ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared ALU / unified memory
// datapath with a request/ready memory handshake.
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | read instruction at PC, PC += 4 on ready
// DECODE    | latch opcode, precompute branch target
// MEMADR    | ALUOut = rs + sext(imm)
// MEMRD     | load request, wait for ready
// MEMWB     | write load data to rt
// MEMWR     | store request, done on ready
// EXEC      | R-type ALU operation
// ALUWB     | write ALU result to rd
// BRANCH    | compare rs/rt, conditional PC update
// IEXEC     | immediate ALU operation
// IWB       | write ALU result to rt
// JUMP      | PC = jump target
// ILLEGAL   | unknown opcode, parked until reset
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input logic               clk,
    input logic               reset,
    multicycle_ctrl_if.master bus
);

    state_t     state;
    state_t     state_nxt;
    logic [5:0] opq;
    logic       mem_rdy;
    ctrl_t      dec;
    ctrl_t      ctrl;

    assign mem_rdy = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            opq   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE)
                opq <= bus.Op;
        end
    end

    // DECODE branches on the live opcode; OpQ only becomes valid afterwards.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (mem_rdy) state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    LW, SW:                 state_nxt = S_MEMADR;
                    RTYPE:                  state_nxt = S_EXEC;
                    BEQ, BNE:               state_nxt = S_BRANCH;
                    ADDI, ANDI, ORI, SLTI:  state_nxt = S_IEXEC;
                    J:                      state_nxt = S_JUMP;
                    default:                state_nxt = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  state_nxt = (opq == LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_rdy) state_nxt = S_MEMWB;
            S_MEMWR:   if (mem_rdy) state_nxt = S_FETCH;
            S_EXEC:    state_nxt = S_ALUWB;
            S_IEXEC:   state_nxt = S_IWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP:
                       state_nxt = S_FETCH;
            S_ILLEGAL: state_nxt = S_ILLEGAL;
            default:   state_nxt = S_FETCH;
        endcase
    end

    multicycle_outdec u_outdec (
        .state   (state),
        .opq     (opq),
        .mem_rdy (mem_rdy),
        .zero    (bus.Zero),
        .ctrl    (dec)
    );

    // Reset blanks every output in the same cycle, abandoning any memory access.
    always_comb begin
        ctrl = dec;
        if (reset)
            ctrl = '0;
    end

    assign bus.MemReq    = ctrl.mem_req;
    assign bus.MemWrite  = ctrl.mem_write;
    assign bus.IorD      = ctrl.iord;
    assign bus.IrWrite   = ctrl.ir_write;
    assign bus.PcEn      = ctrl.pc_en;
    assign bus.PcSrc     = ctrl.pc_src;
    assign bus.AluSrcA   = ctrl.alu_src_a;
    assign bus.AluSrcB   = ctrl.alu_src_b;
    assign bus.AluOp     = ctrl.alu_op;
    assign bus.ExtOp     = ctrl.ext_op;
    assign bus.RegDst    = ctrl.reg_dst;
    assign bus.MemToReg  = ctrl.mem_to_reg;
    assign bus.RegWrite  = ctrl.reg_write;
    assign bus.InstrDone = ctrl.instr_done;
    assign bus.Illegal   = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected cycle
// sequences are built from the instruction semantics and compared every cycle.
module tb_multicycle_ctrl;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       mreq, mwr, iord, irw, pcen;
        logic [1:0] pcsrc;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] aluop;
        logic       ext, rdst, m2r, rw, done, ill;
    } vec_t;

    vec_t exp_q[$];
    logic rdy_q[$];

    function automatic vec_t observe();
        vec_t v;
        v.mreq  = bus.MemReq;    v.mwr  = bus.MemWrite; v.iord = bus.IorD;
        v.irw   = bus.IrWrite;   v.pcen = bus.PcEn;     v.pcsrc = bus.PcSrc;
        v.asa   = bus.AluSrcA;   v.asb  = bus.AluSrcB;  v.aluop = bus.AluOp;
        v.ext   = bus.ExtOp;     v.rdst = bus.RegDst;   v.m2r  = bus.MemToReg;
        v.rw    = bus.RegWrite;  v.done = bus.InstrDone; v.ill = bus.Illegal;
        return v;
    endfunction

    task automatic push(input vec_t e, input logic r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endtask

    // A memory access lasts waits+1 cycles; ready arrives in the last one.
    task automatic mem_access(input vec_t e, input int waits, input logic done_last);
        vec_t v;
        for (int i = 0; i <= waits; i++) begin
            v = e;
            if (i == waits && done_last) v.done = 1'b1;
            push(v, i == waits);
        end
    endtask

    // Reference model: expected cycle-by-cycle controls for one instruction.
    task automatic build(input logic [5:0] op, input logic zero, input int wf, input int wm);
        vec_t e;
        e = '0; e.mreq = 1; e.asb = 2'b01; e.aluop = 3'b010;
        for (int i = 0; i <= wf; i++) begin
            vec_t v;
            v = e;
            if (i == wf) begin v.irw = 1; v.pcen = 1; end
            push(v, i == wf);
        end
        e = '0; e.asb = 2'b11; e.aluop = 3'b010; e.ext = 1;
        push(e, 1'($urandom));
        case (op)
            LW, SW: begin
                e = '0; e.asa = 1; e.asb = 2'b10; e.aluop = 3'b010; e.ext = 1;
                push(e, 1'($urandom));
                e = '0; e.mreq = 1; e.iord = 1;
                if (op == LW) begin
                    mem_access(e, wm, 1'b0);
                    e = '0; e.m2r = 1; e.rw = 1; e.done = 1;
                    push(e, 1'($urandom));
                end else begin
                    e.mwr = 1;
                    mem_access(e, wm, 1'b1);
                end
            end
            RTYPE: begin
                e = '0; e.asa = 1; e.aluop = 3'b011;
                push(e, 1'($urandom));
                e = '0; e.rdst = 1; e.rw = 1; e.done = 1;
                push(e, 1'($urandom));
            end
            BEQ, BNE: begin
                e = '0; e.asa = 1; e.aluop = 3'b110; e.pcsrc = 2'b01; e.done = 1;
                e.pcen = (op == BEQ) ? zero : !zero;
                push(e, 1'($urandom));
            end
            ADDI, ANDI, ORI, SLTI: begin
                e = '0; e.asa = 1; e.asb = 2'b10;
                e.aluop = (op == ADDI) ? 3'b010 : (op == ANDI) ? 3'b000 :
                          (op == ORI) ? 3'b001 : 3'b111;
                e.ext = (op == ADDI || op == SLTI);
                push(e, 1'($urandom));
                e.rw = 1; e.done = 1;
                push(e, 1'($urandom));
            end
            J: begin
                e = '0; e.pcsrc = 2'b10; e.pcen = 1; e.done = 1;
                push(e, 1'($urandom));
            end
            default: begin
                e = '0; e.ill = 1;
                for (int i = 0; i < 10; i++) push(e, 1'($urandom));
            end
        endcase
    endtask

    // Runs up to ncyc cycles (all when negative). After DECODE the Op input
    // is scrambled so that only the latched opcode can steer the sequence.
    task automatic run_instr(input string name, input logic [5:0] op, input logic zero,
                             input int wf, input int wm, input int ncyc);
        vec_t got;
        int n;
        exp_q.delete();
        rdy_q.delete();
        build(op, zero, wf, wm);
        n = (ncyc < 0) ? exp_q.size() : ncyc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.Op = (i <= wf + 1) ? op : 6'($urandom);
            bus.Zero = zero;
            bus.MemReady = rdy_q[i];
            #1;
            got = observe();
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, i + 1, got, exp_q[i]);
            end
        end
    endtask

    task automatic reset_cycle(input string name);
        vec_t got;
        @(negedge clk);
        reset = 1'b1;
        bus.MemReady = 1'($urandom);
        bus.Op = 6'($urandom);
        bus.Zero = 1'($urandom);
        #1;
        got = observe();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL %s: outputs got %h expected 0", name, got);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.Op = '0; bus.Zero = 0; bus.MemReady = 0;
        reset_cycle("reset_initial_a");
        reset = 1'b1;
        reset_cycle("reset_initial_b");
    endtask

    task automatic test_rtype();
        run_instr("rtype", RTYPE, 1'b0, 0, 0, -1);
        run_instr("rtype_after", RTYPE, 1'b1, 1, 0, -1);
    endtask

    task automatic test_lw_wait();
        run_instr("lw_wait2", LW, 1'b0, 0, 2, -1);
        run_instr("sw_nowait", SW, 1'b0, 0, 0, -1);
    endtask

    task automatic test_branch();
        run_instr("beq_z1", BEQ, 1'b1, 0, 0, -1);
        run_instr("beq_z0", BEQ, 1'b0, 0, 0, -1);
        run_instr("bne_z1", BNE, 1'b1, 0, 0, -1);
        run_instr("bne_z0", BNE, 1'b0, 0, 0, -1);
        run_instr("jump", J, 1'b0, 0, 0, -1);
    endtask

    task automatic test_itype();
        run_instr("ori", ORI, 1'b0, 0, 0, -1);
        run_instr("slti", SLTI, 1'b0, 0, 0, -1);
        run_instr("addi", ADDI, 1'b1, 0, 0, -1);
        run_instr("andi", ANDI, 1'b0, 2, 0, -1);
    endtask

    task automatic test_illegal();
        run_instr("illegal", 6'b111111, 1'b0, 0, 0, -1);
        reset_cycle("illegal_reset");
        run_instr("after_illegal", ADDI, 1'b0, 0, 0, -1);
    endtask

    task automatic test_reset_mid_store();
        // Fetch, decode, address, then one MEMWR cycle without ready.
        run_instr("sw_stall", SW, 1'b0, 0, 5, 4);
        reset_cycle("sw_reset");
        run_instr("after_sw_reset", RTYPE, 1'b0, 0, 0, -1);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [10];
        ops = '{RTYPE, ADDI, ANDI, ORI, SLTI, BEQ, BNE, LW, SW, J};
        for (int k = 0; k < 40; k++) begin
            run_instr("random", ops[$urandom_range(0, 9)], 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_itype();
        test_illegal();
        test_reset_mid_store();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM that sequences the shared MIPS datapath: one ALU and one unified instruction/data memory port, for the same ISA subset as the main decoder (R-type, addi, andi, ori, slti, beq, bne, lw, sw, j).
- Sits beside the datapath and drives its mux selects and write strobes each cycle.
- Performs a request/ready handshake with the memory port, so memory latency may vary.

Parameters:
- MEM_HANDSHAKE, 1, if 1 memory states wait for MemReady; if 0 MemReady is treated as constant 1 (single-cycle memory).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- Op  in  6  opcode field of the instruction register
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current request this cycle
- MemReq  out  1  memory access request
- MemWrite  out  1  store (valid with MemReq)
- IorD  out  1  address select: 0 = PC, 1 = ALUOut
- IrWrite  out  1  load instruction register
- PcEn  out  1  PC write enable, combined with the branch condition
- PcSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- AluSrcA  out  1  0 = PC, 1 = rs
- AluSrcB  out  2  00 = rt, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
- AluOp  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 011 decode funct
- ExtOp  out  1  1 = sign-extend, 0 = zero-extend
- RegDst  out  1  1 = rd, 0 = rt
- MemToReg  out  1  writeback from memory data
- RegWrite  out  1  register file write
- InstrDone  out  1  one-cycle pulse in the final cycle of each instruction
- Illegal  out  1  sticky illegal-opcode flag

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high.
- Reset: while reset is high, every output is 0. Next state is FETCH, OpQ clears to 0, Illegal clears to 0.
- Reset mid-operation abandons any memory access: MemReq drops in the reset cycle.
- State register is 4 bits. Op is latched into OpQ in DECODE. All later decisions use OpQ.
- Outputs not listed for a state are 0.
- FETCH:
  - MemReq=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=010.
  - IrWrite and PcWrite assert only in the MemReady cycle; the transition to DECODE happens in that same cycle.
  - Without MemReady, stay in FETCH with MemReq held.
- DECODE:
  - AluSrcA=0, AluSrcB=11, AluOp=010, ExtOp=1 (branch target precompute).
  - Next state: lw/sw→MEMADR, R-type→EXEC, beq/bne→BRANCH, addi/andi/ori/slti→IEXEC, j→JUMP, any other opcode→ILLEGAL.
- MEMADR: AluSrcA=1, AluSrcB=10, ExtOp=1, AluOp=010. Next state: lw→MEMRD, sw→MEMWR.
- MEMRD: MemReq=1, IorD=1. On MemReady go to MEMWB.
- MEMWB: RegDst=0, MemToReg=1, RegWrite=1, InstrDone=1. Next state FETCH.
- MEMWR: MemReq=1, MemWrite=1, IorD=1. On MemReady: InstrDone=1, go to FETCH.
- EXEC: AluSrcA=1, AluSrcB=00, AluOp=011. Next state ALUWB.
- ALUWB: RegDst=1, RegWrite=1, InstrDone=1. Next state FETCH.
- BRANCH:
  - AluSrcA=1, AluSrcB=00, AluOp=110, PcSrc=01, InstrDone=1. Next state FETCH.
  - PcEn = Zero XOR (OpQ==bne).
- IEXEC:
  - AluSrcA=1, AluSrcB=10.
  - AluOp: addi 010, andi 000, ori 001, slti 111.
  - ExtOp=1 for addi/slti, 0 for andi/ori.
  - Next state IWB.
- IWB: RegDst=0, MemToReg=0, RegWrite=1, InstrDone=1. ALU controls are held from IEXEC. Next state FETCH.
- JUMP: PcSrc=10, PcEn=1, InstrDone=1. Next state FETCH.
- ILLEGAL: Illegal=1. Absorbing state, no strobes; only reset exits.
- PcEn outside BRANCH equals PcWrite.
- Latency with zero-wait memory:
  - R-type/I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne/j: 3 cycles
  - Each MemReady-low cycle adds 1.
- MemReady outside a MemReq state is ignored.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (RTYPE, ADDI, ANDI, ORI, SLTI, BEQ, BNE, LW, SW, J)
  - AluOp encodings
  - PcSrc/AluSrcB encodings
  - state enum
- The main decoder and this block both import it.
- Sub-module multicycle_outdec: combinational map from (state, OpQ, MemReady, Zero) to the output bundle. The FSM core keeps only the state and OpQ registers and the next-state logic.

Test Plan:
- R-type, MemReady always 1 → IrWrite pulse in cycle 1; RegWrite=1, RegDst=1 in cycle 4; InstrDone in cycle 4; next cycle FETCH.
- lw with MemReady low 2 cycles in MEMRD → MemReq=1, IorD=1 held 3 cycles; MemToReg=1, RegWrite=1 in cycle 7; InstrDone once.
- beq Zero=1 → PcEn=1, PcSrc=01 in cycle 3. bne Zero=1 → PcEn=0. bne Zero=0 → PcEn=1.
- ori then slti → ori: AluOp=001, ExtOp=0. slti: AluOp=111, ExtOp=1. Both have RegDst=0 in IWB.
- Op=6'b111111 → ILLEGAL after DECODE; Illegal=1 sticky, no MemReq for 10 cycles; reset clears it and restarts FETCH.
- reset asserted during MEMWR with MemReady=0 → MemReq=0 and MemWrite=0 in the reset cycle; FETCH after release; no InstrDone.
